// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller/datapath bundle: opcode and memory handshake in, controls out
interface multicycle_controller_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             pcwrite;
    logic             branch;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic [1:0]       pcsrc;
    logic [3:0]       state;
    logic             illegal_op;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  opcode, mem_ready,
        output iord, memwrite, irwrite, pcwrite, branch, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, state, illegal_op, fetch_count
    );

    modport slave (
        output opcode, mem_ready,
        input  iord, memwrite, irwrite, pcwrite, branch, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, state, illegal_op, fetch_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-style control FSM with memory wait states
module multicycle_controller #(
    parameter bit SUPPORT_ADDI = 1'b1,
    parameter bit SUPPORT_J    = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q;
    state_t           state_d;
    logic [5:0]       opcode_q;
    logic [CNT_W-1:0] fetch_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            opcode_q  <= 6'b000000;
            fetch_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                opcode_q <= bus.opcode;
            end
            if (state_q == FETCH && bus.mem_ready) begin
                fetch_cnt <= fetch_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = FETCH;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcwrite    = 1'b0;
        bus.branch     = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.aluop      = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
                state_d     = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI: begin
                        if (SUPPORT_ADDI) state_d = ADDIEX;
                        else              bus.illegal_op = 1'b1;
                    end
                    OP_J: begin
                        if (SUPPORT_J) state_d = JEX;
                        else           bus.illegal_op = 1'b1;
                    end
                    default: bus.illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                // the live opcode may already have moved on; use the copy taken in DECODE
                state_d     = (opcode_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.iord = 1'b1;
                state_d  = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                state_d      = bus.mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BEQEX: begin
                bus.alusrca = 1'b1;
                bus.branch  = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                bus.regwrite = 1'b1;
            end
            JEX: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.fetch_count = fetch_cnt;
endmodule
